// File: rtl/pedagio_pkg.sv
// Shared definitions for the toll-lane revenue arbiter: category codes,
// BCD tariffs, FSM state encoding and BCD digit width.
package pedagio_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] CAT_INV = 2'd0;
  localparam logic [1:0] CAT_1   = 2'd1;
  localparam logic [1:0] CAT_2   = 2'd2;
  localparam logic [1:0] CAT_3   = 2'd3;

  // Tariffs as two packed BCD digits; all higher digits of the addend are zero.
  localparam int         TARIFA_DIGITS = 2;
  localparam logic [7:0] TARIFA_1 = 8'h10;
  localparam logic [7:0] TARIFA_2 = 8'h25;
  localparam logic [7:0] TARIFA_3 = 8'h50;

  typedef enum logic [1:0] {IDLE, ARB, ADD, ACK} state_t;

  function automatic logic [7:0] tarifa_bcd(input logic [1:0] c);
    case (c)
      CAT_1:   return TARIFA_1;
      CAT_2:   return TARIFA_2;
      CAT_3:   return TARIFA_3;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with decimal correction; time-shared across the digits
// of the shared total by the sequencing FSM.
module bcd_digit_add
  import pedagio_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] digit,
  output logic               cout
);

  logic [DIGIT_W:0] raw;

  // binary sum, then subtract ten (mod 16) when the digit exceeds nine
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    if (raw > (DIGIT_W+1)'(9)) begin
      digit = raw[DIGIT_W-1:0] - DIGIT_W'(10);
      cout  = 1'b1;
    end else begin
      digit = raw[DIGIT_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/pedagio_arbitro_faixas.sv
// Round-robin arbiter that lets several toll lanes share one BCD revenue
// accumulator, adding one digit per clock.
// Optional macro PEDAGIO_CONTAGEM_EN adds per-category transaction counters
// on output cnt_cat (cat1 at LSBs, 8 bits each).
module pedagio_arbitro_faixas
  import pedagio_pkg::*;
#(
  parameter int N_LANES  = 4,
  parameter int N_DIGITS = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          nRESET,
  input  logic [N_LANES-1:0]            req,
  input  logic [2*N_LANES-1:0]          cat,
`ifdef PEDAGIO_CONTAGEM_EN
  output logic [23:0]                   cnt_cat,
`endif
  output logic [N_LANES-1:0]            ack,
  output logic [N_LANES-1:0]            reject,
  output logic [$clog2(N_LANES)-1:0]    gnt_id,
  output logic                          busy,
  output logic [DIGIT_W*N_DIGITS-1:0]   total_bcd,
  output logic                          overflow
);

  localparam int ID_W = $clog2(N_LANES);
  localparam int K_W  = $clog2(N_DIGITS);

  state_t                      state_reg, state_next;
  logic [ID_W-1:0]             rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]             gnt_id_reg, gnt_id_next;
  logic [7:0]                  addend_reg, addend_next;
  logic [DIGIT_W*N_DIGITS-1:0] total_reg, total_next;
  logic [K_W-1:0]              k_reg, k_next;
  logic                        carry_reg, carry_next;
  logic                        overflow_reg, overflow_next;
  logic                        reject_reg, reject_next;

  logic                        found;
  logic [ID_W-1:0]             winner;
  logic [ID_W-1:0]             lane_idx;
  int                          idx;
  logic [1:0]                  cat_sel;
  logic [DIGIT_W-1:0]          digit_a, digit_b, digit_sum;
  logic                        carry_sum;

  // round-robin search from rr_ptr, wrapping, first requesting lane wins
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    lane_idx = '0;
    idx      = 0;
    for (int i = 0; i < N_LANES; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= N_LANES) idx = idx - N_LANES;
      lane_idx = idx[ID_W-1:0];
      if (!found && req[lane_idx]) begin
        found  = 1'b1;
        winner = lane_idx;
      end
    end
    cat_sel = cat[winner*2 +: 2];
  end

  // operands for the digit currently being added; only the low tariff digits are non-zero
  always_comb begin
    digit_a = total_reg[k_reg*DIGIT_W +: DIGIT_W];
    digit_b = (k_reg < K_W'(TARIFA_DIGITS)) ? addend_reg[k_reg[0]*DIGIT_W +: DIGIT_W] : '0;
  end

  bcd_digit_add u_add (
    .a     (digit_a),
    .b     (digit_b),
    .cin   (carry_reg),
    .digit (digit_sum),
    .cout  (carry_sum)
  );

  // next-state and datapath updates for the sequencing FSM
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    gnt_id_next   = gnt_id_reg;
    addend_next   = addend_reg;
    total_next    = total_reg;
    k_next        = k_reg;
    carry_next    = carry_reg;
    overflow_next = overflow_reg;
    reject_next   = reject_reg;
    case (state_reg)
      IDLE: if (|req) state_next = ARB;
      ARB: begin
        if (!found) begin
          state_next = IDLE;                       // request withdrawn before grant
        end else begin
          gnt_id_next = winner;
          rr_ptr_next = (winner == ID_W'(N_LANES-1)) ? '0 : winner + 1'b1;
          if (cat_sel == CAT_INV) begin
            reject_next = 1'b1;
            state_next  = ACK;
          end else begin
            reject_next = 1'b0;
            addend_next = tarifa_bcd(cat_sel);
            k_next      = '0;
            carry_next  = 1'b0;
            state_next  = ADD;
          end
        end
      end
      ADD: begin
        total_next[k_reg*DIGIT_W +: DIGIT_W] = digit_sum;
        carry_next = carry_sum;
        k_next     = k_reg + 1'b1;
        if (k_reg == K_W'(N_DIGITS-1)) begin
          state_next = ACK;
          if (carry_sum) overflow_next = 1'b1;     // total wraps modulo 10^N_DIGITS
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // state and datapath registers, asynchronously cleared
  always_ff @(posedge CLOCK_50 or negedge nRESET) begin
    if (!nRESET) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      gnt_id_reg   <= '0;
      addend_reg   <= '0;
      total_reg    <= '0;
      k_reg        <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      reject_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      gnt_id_reg   <= gnt_id_next;
      addend_reg   <= addend_next;
      total_reg    <= total_next;
      k_reg        <= k_next;
      carry_reg    <= carry_next;
      overflow_reg <= overflow_next;
      reject_reg   <= reject_next;
    end
  end

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane_out
      assign ack[gi]    = (state_reg == ACK) && (gnt_id_reg == ID_W'(gi));
      assign reject[gi] = (state_reg == ACK) && (gnt_id_reg == ID_W'(gi)) && reject_reg;
    end
  endgenerate

  assign gnt_id    = gnt_id_reg;
  assign busy      = (state_reg != IDLE);
  assign total_bcd = total_reg;
  assign overflow  = overflow_reg;

`ifdef PEDAGIO_CONTAGEM_EN
  logic [1:0]  cat_reg;
  logic [23:0] cnt_reg;

  // latch the granted category, count each accepted transaction as it acks
  always_ff @(posedge CLOCK_50 or negedge nRESET) begin
    if (!nRESET) begin
      cat_reg <= CAT_INV;
      cnt_reg <= '0;
    end else begin
      if (state_reg == ARB && found) cat_reg <= cat_sel;
      if (state_reg == ACK && !reject_reg)
        cnt_reg[(cat_reg-2'd1)*8 +: 8] <= cnt_reg[(cat_reg-2'd1)*8 +: 8] + 8'd1;
    end
  end

  assign cnt_cat = cnt_reg;
`endif

endmodule
